sampq_buffer: RTL and testbench

Sample queue buffer downstream of the ADC accumulator stages. It accepts 32-bit sample queue entries on `sample`/`sample_avail` and stores them in a synchronous FIFO. It serializes them LSB-first as a valid/ready byte stream toward the host transport. It exposes status, fill level and overflow count on the same 8-bit wishbone register port style as the producer stages.

---
 rtl/sampq_buffer_pkg.sv | 33 +++
 rtl/sampq_buffer_if.sv | 29 ++
 rtl/sampq_ram.sv | 28 ++
 rtl/sampq_buffer.sv | 202 ++++++++++++++++++++
 tb/tb_sampq_buffer.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sampq_buffer_pkg.sv
// Shared definitions for the sample queue buffer: register map, status bit
// positions, configuration bit positions and serializer state encoding.
package sampq_buffer_pkg;

  // Register addresses (wb_adr_i[1:0])
  localparam logic [1:0] SQB_REG_STATUS   = 2'd0;
  localparam logic [1:0] SQB_REG_COUNT    = 2'd1;
  localparam logic [1:0] SQB_REG_OVERFLOW = 2'd2;
  localparam logic [1:0] SQB_REG_RSVD     = 2'd3;

  // Status register bit positions (read of address 0)
  localparam int SQB_ST_ENABLE   = 0;
  localparam int SQB_ST_EMPTY    = 1;
  localparam int SQB_ST_FULL     = 2;
  localparam int SQB_ST_OVERFLOW = 3;

  // Configuration bit positions (write of address 0)
  localparam int SQB_CFG_ENABLE = 0;
  localparam int SQB_CFG_FLUSH  = 1;

  // Serializer states
  typedef enum logic [1:0] {
    SQB_IDLE  = 2'd0,
    SQB_FETCH = 2'd1,
    SQB_SEND  = 2'd2
  } sqb_state_e;

  // Saturating 8-bit increment used by the overflow counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sampq_buffer_if.sv
// Bundle of the sample input, byte stream output and wishbone register port.
// slave: the buffer itself; master: whoever drives samples/consumes bytes.
interface sampq_buffer_if;
  logic [31:0] sample;
  logic        sample_avail;
  logic        sq_active;
  logic [7:0]  out_dat;
  logic        out_valid;
  logic        out_ready;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [15:0] wb_adr_i;
  logic [7:0]  wb_dat_i;
  logic [7:0]  wb_dat_o;
  logic        wb_ack_o;

  modport slave (
    input  sample, sample_avail, sq_active, out_ready,
    input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
    output out_dat, out_valid, wb_dat_o, wb_ack_o
  );

  modport master (
    output sample, sample_avail, sq_active, out_ready,
    output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  out_dat, out_valid, wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/sampq_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// A read and write to the same address in one cycle returns the old data.
module sampq_ram #(
  parameter int DEPTH_BITS = 6,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [DEPTH_BITS-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_BITS];

  // Write port and registered read port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sampq_buffer.sv
// Sample queue buffer: 32-bit FIFO in block RAM, LSB-first byte serializer
// with valid/ready output, and an 8-bit wishbone status/config port.
module sampq_buffer
  import sampq_buffer_pkg::*;
#(
  parameter int DEPTH_BITS = 6
) (
  input logic           clk,
  input logic           rst,
  sampq_buffer_if.slave bus
);

  localparam logic [DEPTH_BITS:0] FIFO_DEPTH = {1'b1, {DEPTH_BITS{1'b0}}};

  sqb_state_e            state_q, state_d;
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]   count_q, count_d;
  logic                  enable_q, enable_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            ovf_cnt_q, ovf_cnt_d;
  logic [31:0]           shreg_q, shreg_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic                  out_valid_q, out_valid_d;

  logic [31:0] ram_rdata;
  logic        cfg_wr;
  logic        flush;
  logic        empty;
  logic        full;
  logic        handshake;
  logic        pop;
  logic        push_try;
  logic        push_ok;
  logic        push_rej;
  logic [7:0]  count_byte;
  logic        unused_bits;

  assign cfg_wr = bus.wb_stb_i & bus.wb_cyc_i & bus.wb_we_i &
                  (bus.wb_adr_i[1:0] == SQB_REG_STATUS) & ~bus.sq_active;
  assign flush     = cfg_wr & bus.wb_dat_i[SQB_CFG_FLUSH];
  assign empty     = (count_q == '0);
  assign full      = (count_q == FIFO_DEPTH);
  assign handshake = out_valid_q & bus.out_ready;
  assign push_try  = bus.sample_avail & enable_q;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts
  assign push_ok   = push_try & ~flush & (~full | pop);
  assign push_rej  = push_try & ~flush & full & ~pop;

  assign unused_bits = ^{bus.wb_adr_i[15:2], bus.wb_dat_i[7:2]};

  sampq_ram #(
    .DEPTH_BITS(DEPTH_BITS),
    .WIDTH     (32)
  ) u_ram (
    .clk  (clk),
    .we   (push_ok),
    .waddr(wr_ptr_q),
    .wdata(bus.sample),
    .re   (pop),
    .raddr(rd_ptr_q),
    .rdata(ram_rdata)
  );

  // Serializer next state: pop in IDLE or after the last byte, load in FETCH
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    byte_idx_d  = byte_idx_q;
    out_valid_d = out_valid_q;
    pop         = 1'b0;
    case (state_q)
      SQB_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = SQB_FETCH;
        end
      end
      SQB_FETCH: begin
        shreg_d     = ram_rdata;
        byte_idx_d  = 2'd0;
        out_valid_d = 1'b1;
        state_d     = SQB_SEND;
      end
      SQB_SEND: begin
        if (handshake) begin
          shreg_d    = {8'h00, shreg_q[31:8]};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // The FETCH cycle is a bubble, so valid drops either way
            out_valid_d = 1'b0;
            if (!empty) begin
              pop     = 1'b1;
              state_d = SQB_FETCH;
            end else begin
              state_d = SQB_IDLE;
            end
          end
        end
      end
      default: state_d = SQB_IDLE;
    endcase
    if (flush) begin
      state_d     = SQB_IDLE;
      out_valid_d = 1'b0;
      byte_idx_d  = 2'd0;
    end
  end

  // Pointer, fill level, overflow tracking and enable
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    ovf_cnt_d  = ovf_cnt_q;
    enable_d   = enable_q;
    if (cfg_wr) begin
      enable_d = bus.wb_dat_i[SQB_CFG_ENABLE];
    end
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      ovf_cnt_d  = 8'd0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + DEPTH_BITS'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + DEPTH_BITS'(1);
      end
      if (push_rej) begin
        overflow_d = 1'b1;
        ovf_cnt_d  = sat_inc8(ovf_cnt_q);
      end
      if (push_ok && !pop) begin
        count_d = count_q + (DEPTH_BITS+1)'(1);
      end else if (!push_ok && pop) begin
        count_d = count_q - (DEPTH_BITS+1)'(1);
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SQB_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      enable_q    <= 1'b0;
      overflow_q  <= 1'b0;
      ovf_cnt_q   <= 8'd0;
      shreg_q     <= 32'd0;
      byte_idx_q  <= 2'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      enable_q    <= enable_d;
      overflow_q  <= overflow_d;
      ovf_cnt_q   <= ovf_cnt_d;
      shreg_q     <= shreg_d;
      byte_idx_q  <= byte_idx_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Fill level presented as one byte; zero-extended for small FIFOs
  generate
    if (DEPTH_BITS >= 7) begin : g_count_wide
      assign count_byte = count_q[7:0];
    end else begin : g_count_narrow
      assign count_byte = {{(7-DEPTH_BITS){1'b0}}, count_q};
    end
  endgenerate

  // Combinational register read mux
  always_comb begin
    bus.wb_dat_o = 8'h00;
    case (bus.wb_adr_i[1:0])
      SQB_REG_STATUS: begin
        bus.wb_dat_o[SQB_ST_ENABLE]   = enable_q;
        bus.wb_dat_o[SQB_ST_EMPTY]    = empty;
        bus.wb_dat_o[SQB_ST_FULL]     = full;
        bus.wb_dat_o[SQB_ST_OVERFLOW] = overflow_q;
      end
      SQB_REG_COUNT:    bus.wb_dat_o = count_byte;
      SQB_REG_OVERFLOW: bus.wb_dat_o = ovf_cnt_q;
      default:          bus.wb_dat_o = 8'h00;
    endcase
  end

  assign bus.out_dat   = shreg_q[7:0];
  assign bus.out_valid = out_valid_q;
  assign bus.wb_ack_o  = 1'b1;

endmodule

// File: tb/tb_sampq_buffer.sv
// Self-checking bench for sampq_buffer: directed scenarios with literal
// expectations plus a randomized phase, all cross-checked every cycle
// against a queue-based behavioural model.
module tb_sampq_buffer;

  localparam int DEPTH_BITS = 6;
  localparam int DEPTH      = 64;

  logic clk;
  logic rst;
  sampq_buffer_if bus();

  sampq_buffer #(.DEPTH_BITS(DEPTH_BITS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_q[$];
  bit          m_live = 1'b0;
  bit          m_en, m_ovf;
  int          m_ovfcnt;
  bit          m_fetch;          // a word left the FIFO last edge, shows next
  logic [31:0] m_fetch_word;
  bit          m_have;           // a word is being presented on the stream
  logic [31:0] m_word;
  int          m_sent;
  bit          m_wr0, m_flush, m_hs, m_last, m_pop, m_push;
  logic [31:0] m_popped;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_en = 0; m_ovf = 0; m_ovfcnt = 0;
      m_fetch = 0; m_have = 0; m_sent = 0;
      m_live = 1'b1;
    end else begin
      m_wr0   = bus.wb_stb_i && bus.wb_cyc_i && bus.wb_we_i &&
                (bus.wb_adr_i[1:0] == 2'd0) && !bus.sq_active;
      m_flush = m_wr0 && bus.wb_dat_i[1];
      m_hs    = m_have && bus.out_ready;
      m_last  = m_hs && (m_sent == 3);
      m_pop   = (m_q.size() != 0) && ((!m_have && !m_fetch) || m_last);
      m_push  = bus.sample_avail && m_en;
      if (m_wr0) m_en = bus.wb_dat_i[0];
      if (m_flush) begin
        m_q.delete();
        m_have = 0; m_fetch = 0; m_sent = 0;
        m_ovf = 0; m_ovfcnt = 0;
      end else begin
        m_popped = 32'd0;
        if (m_pop) m_popped = m_q.pop_front();
        if (m_push) begin
          if (m_q.size() < DEPTH) m_q.push_back(bus.sample);
          else begin
            m_ovf = 1;
            if (m_ovfcnt < 255) m_ovfcnt++;
          end
        end
        if (m_fetch) begin
          m_have = 1; m_word = m_fetch_word; m_sent = 0;
        end else if (m_hs) begin
          m_sent++;
          if (m_sent == 4) m_have = 0;
        end
        m_fetch = m_pop;
        if (m_pop) m_fetch_word = m_popped;
      end
    end
  end

  function automatic logic [7:0] exp_reg(input logic [1:0] a);
    case (a)
      2'd0: return {4'b0, m_ovf, (m_q.size() == DEPTH), (m_q.size() == 0), m_en};
      2'd1: return 8'(m_q.size());
      2'd2: return 8'(m_ovfcnt);
      default: return 8'h00;
    endcase
  endfunction

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_live) begin
      check("out_valid", 32'(bus.out_valid), 32'(m_have));
      if (m_have) check("out_dat", 32'(bus.out_dat), 32'(8'(m_word >> (8 * m_sent))));
      check("wb_dat_o", 32'(bus.wb_dat_o), 32'(exp_reg(bus.wb_adr_i[1:0])));
      check("wb_ack_o", 32'(bus.wb_ack_o), 32'd1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    bus.wb_stb_i = 1; bus.wb_cyc_i = 1; bus.wb_we_i = 0;
    bus.wb_adr_i = {14'd0, a};
    #1;
    v = bus.wb_dat_o;
  endtask

  task automatic wr0(input logic [7:0] d, input logic act);
    bus.wb_stb_i = 1; bus.wb_cyc_i = 1; bus.wb_we_i = 1;
    bus.wb_adr_i = 16'd0; bus.wb_dat_i = d; bus.sq_active = act;
    step();
    bus.wb_we_i = 0; bus.sq_active = 0;
    $display("write addr0 data=%02h sq_active=%0b", d, act);
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.sample = $urandom; bus.sample_avail = 1;
      step();
    end
    bus.sample_avail = 0;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20 && !bus.out_valid; i++) step();
    check(name, 32'(bus.out_valid), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  logic [7:0]  v;
  logic [63:0] pair;
  logic [31:0] word;
  int          lat, got;

  initial begin
    rst = 1; bus.sample = 0; bus.sample_avail = 0; bus.sq_active = 0;
    bus.out_ready = 0; bus.wb_stb_i = 0; bus.wb_cyc_i = 0; bus.wb_we_i = 0;
    bus.wb_adr_i = 0; bus.wb_dat_i = 0;
    step(); step(); step();
    rst = 0; step();

    // Reset and configuration
    rd(2'd0, v); check("reset_status", 32'(v), 32'h02);
    check("reset_valid", 32'(bus.out_valid), 32'd0);
    check("reset_dat", 32'(bus.out_dat), 32'd0);
    wr0(8'h01, 1'b0);
    rd(2'd0, v); check("enable_status", 32'(v), 32'h03);
    wr0(8'h00, 1'b1);
    rd(2'd0, v); check("active_ignored", 32'(v), 32'h03);

    // Single word, latency and byte order
    bus.out_ready = 1;
    bus.sample = 32'hDDCCBBAA; bus.sample_avail = 1;
    step(); bus.sample_avail = 0;
    $display("push 0xDDCCBBAA");
    lat = 1;
    while (!bus.out_valid && lat < 10) begin step(); lat++; end
    check("latency", 32'(lat), 32'd3);
    word = 32'hDDCCBBAA;
    for (int b = 0; b < 4; b++) begin
      check("single_byte", 32'(bus.out_dat), 32'(word[8*b +: 8]));
      check("single_valid", 32'(bus.out_valid), 32'd1);
      step();
    end
    check("single_end", 32'(bus.out_valid), 32'd0);

    // Backpressure with two queued words
    bus.out_ready = 0;
    pair = {$urandom, $urandom};
    bus.sample = pair[31:0];  bus.sample_avail = 1; step();
    bus.sample = pair[63:32]; step();
    bus.sample_avail = 0;
    $display("push %08h %08h under backpressure", pair[31:0], pair[63:32]);
    repeat (10) step();
    check("bp_dat", 32'(bus.out_dat), 32'(pair[7:0]));
    check("bp_valid", 32'(bus.out_valid), 32'd1);
    rd(2'd1, v); check("bp_count", 32'(v), 32'd1);
    bus.out_ready = 1;
    got = 0;
    for (int c = 0; c < 9; c++) begin
      if (bus.out_valid) begin
        check("bp_byte", 32'(bus.out_dat), 32'(pair[8*got +: 8]));
        got++;
      end
      step();
    end
    check("bp_bytes", 32'(got), 32'd8);
    check("bp_end", 32'(bus.out_valid), 32'd0);

    // Overflow
    bus.out_ready = 0;
    push_n(70);
    $display("pushed 70 words with out_ready low");
    rd(2'd1, v); check("ovf_count", 32'(v), 32'd64);
    rd(2'd2, v); check("ovf_drops", 32'(v), 32'd5);
    rd(2'd0, v); check("ovf_status", 32'(v), 32'h0D);
    push_n(300);
    rd(2'd2, v); check("ovf_saturate", 32'(v), 32'd255);

    // Full with simultaneous push and pop
    wr0(8'h03, 1'b0);
    push_n(65);
    rd(2'd1, v); check("refill_count", 32'(v), 32'd64);
    bus.out_ready = 1;
    step(); step(); step();
    bus.sample = $urandom; bus.sample_avail = 1;
    step();
    bus.sample_avail = 0; bus.out_ready = 0;
    $display("push coincident with pop while full");
    rd(2'd1, v); check("pushpop_count", 32'(v), 32'd64);
    rd(2'd2, v); check("pushpop_ovf", 32'(v), 32'd0);
    rd(2'd0, v); check("pushpop_status", 32'(v), 32'h05);
    push_n(3);
    rd(2'd2, v); check("ovf_three", 32'(v), 32'd3);

    // Flush mid-word
    bus.out_ready = 1;
    wait_valid("flush_wait");
    step(); step();
    bus.out_ready = 0;
    wr0(8'h03, 1'b0);
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    rd(2'd1, v); check("flush_count", 32'(v), 32'd0);
    rd(2'd2, v); check("flush_ovf", 32'(v), 32'd0);
    rd(2'd0, v); check("flush_status", 32'(v), 32'h03);
    bus.out_ready = 1;
    bus.sample = 32'h44332211; bus.sample_avail = 1;
    step(); bus.sample_avail = 0;
    $display("push 0x44332211 after flush");
    wait_valid("restart_wait");
    check("restart_b0", 32'(bus.out_dat), 32'h11);
    step();
    check("restart_b1", 32'(bus.out_dat), 32'h22);

    // Randomized traffic checked by the model
    for (int c = 0; c < 4000; c++) begin
      bus.sample       = $urandom;
      bus.sample_avail = ($urandom_range(0, 1) == 1);
      bus.out_ready    = ($urandom_range(0, 9) < 7);
      bus.wb_stb_i     = 1; bus.wb_cyc_i = 1;
      bus.wb_adr_i     = 16'($urandom);
      bus.wb_dat_i     = 8'($urandom);
      bus.sq_active    = ($urandom_range(0, 1) == 1);
      bus.wb_we_i      = ($urandom_range(0, 39) == 0);
      if (bus.wb_we_i && bus.wb_adr_i[1:0] == 2'd0 && $urandom_range(0, 3) != 0)
        bus.wb_dat_i[0] = 1'b1;
      if (c % 500 == 0 && bus.wb_we_i == 0) bus.wb_dat_i = 8'h01;
      rst = ($urandom_range(0, 799) == 0);
      step();
      rst = 0;
      if (c % 500 == 0) begin
        bus.wb_we_i = 1; bus.wb_adr_i = 16'd0; bus.wb_dat_i = 8'h01; bus.sq_active = 0;
        step();
        bus.wb_we_i = 0;
      end
    end
    bus.wb_we_i = 0; bus.sample_avail = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
